// File: rtl/rr_arb_mux.sv
// Registered N-to-1 arbitrated multiplexer with per-channel valid/ready handshakes,
// round-robin or fixed-priority selection, and a one-entry output register.
module rr_arb_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(CHANNELS - 1);

  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] base_idx;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS-1:0] next_ptr;
  logic                grant_valid;
  logic                can_load;
  logic                load;
  int unsigned         scan_idx;
  logic [WIDTH-1:0]    chan_word [CHANNELS];

  // Unpack the flat input bus into one word per channel.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Fixed priority is a round-robin search that always starts at channel 0.
  assign base_idx = mode ? '0 : rr_ptr;

  // Scan from base_idx with wrap; scan_idx stays within 0..CHANNELS-1 so
  // indices beyond the last channel are never considered.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      scan_idx = 32'(base_idx) + k;
      if (scan_idx >= CHANNELS) begin
        scan_idx = scan_idx - CHANNELS;
      end
      if (!grant_valid && in_valid[SEL_BITS'(scan_idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_BITS'(scan_idx);
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign load     = can_load && grant_valid && !reset;
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_BITS'(1);

  // Accept strobe for the granted channel only.
  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= chan_word[grant_idx];
      out_sel   <= grant_idx;
      if (!mode) begin
        rr_ptr <= next_ptr;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: per-cycle reference model on the 4x8 instance,
// literal expectations on both the 4x8 and the 3x16 instance.
module tb_rr_arb_mux;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic        b_mode;
  logic [47:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_valid;
  logic        b_out_ready;

  int vectors;
  int miscompares;

  logic        m_valid;
  logic [7:0]  m_data;
  int          m_sel;
  int          m_ptr;

  int          rr_seq [6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0]  rr_byte [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  int          b_seq [4] = '{0, 1, 2, 0};
  logic [15:0] b_word [3] = '{16'hBEEF, 16'h1234, 16'hCAFE};

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .SEL_BITS(2)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(16), .CHANNELS(3), .SEL_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .mode(b_mode),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel chosen by the arbitration rules, or -1 when nobody is valid.
  function automatic int m_grant(input logic [3:0] v, input logic md, input int ptr);
    if (md) begin
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 0; k < 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Reference model: check outputs, then advance on the inputs seen before the edge.
  always @(negedge clk) begin
    int         g;
    logic       cl;
    logic [3:0] exp_rdy;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
    end
    chk("model out_valid", 32'(out_valid), 32'(m_valid));
    chk("model out_data", 32'(out_data), 32'(m_data));
    chk("model out_sel", 32'(out_sel), 32'(m_sel));
    cl      = !m_valid || out_ready;
    g       = m_grant(in_valid, mode, m_ptr);
    exp_rdy = 4'b0000;
    if (!reset && cl && g >= 0) exp_rdy[g] = 1'b1;
    chk("model in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!reset) begin
      if (cl && g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*8 +: 8];
        m_sel   = g;
        if (!mode) m_ptr = (g + 1) % 4;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_valid     = 1'b0;
    m_data      = 8'h00;
    m_sel       = 0;
    m_ptr       = 0;
    reset       = 1'b1;
    mode        = 1'b0;
    in_data     = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid    = 4'b1111;
    out_ready   = 1'b1;
    b_mode      = 1'b0;
    b_in_data   = {16'hCAFE, 16'h1234, 16'hBEEF};
    b_in_valid  = 3'b000;
    b_out_ready = 1'b1;

    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset b_out_valid", 32'(b_out_valid), 32'd0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr out_sel", 32'(out_sel), 32'(rr_seq[i]));
      chk("rr out_data", 32'(out_data), 32'(rr_byte[rr_seq[i]]));
    end

    in_data[23:16] = 8'h5C;
    step();
    chk("bp load sel", 32'(out_sel), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp hold data", 32'(out_data), 32'h5C);
      chk("bp hold sel", 32'(out_sel), 32'd2);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp next sel", 32'(out_sel), 32'd3);
    chk("bp next data", 32'(out_data), 32'h43);

    in_valid = 4'b0100;
    step();
    chk("wrap setup sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0011;
    step();
    chk("wrap sel ch0", 32'(out_sel), 32'd0);
    step();
    chk("wrap sel ch1", 32'(out_sel), 32'd1);
    in_valid = 4'b1000;
    step();
    chk("sparse sel ch3", 32'(out_sel), 32'd3);

    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fixed out_sel", 32'(out_sel), 32'd1);
      chk("fixed out_data", 32'(out_data), 32'h21);
    end
    mode     = 1'b0;
    in_valid = 4'b1111;
    step();
    chk("ptr kept by fixed", 32'(out_sel), 32'd0);

    in_valid = 4'b0000;
    step();
    chk("drain valid", 32'(out_valid), 32'd0);
    chk("drain data kept", 32'(out_data), 32'h10);

    in_data[7:0] = 8'hA5;
    in_valid     = 4'b0001;
    out_ready    = 1'b0;
    step();
    chk("pre-reset data", 32'(out_data), 32'hA5);
    in_valid = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    chk("midrst out_sel", 32'(out_sel), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post-reset sel", 32'(out_sel), 32'd0);
    chk("post-reset data", 32'(out_data), 32'hA5);

    b_in_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b out_sel", 32'(b_out_sel), 32'(b_seq[i]));
      chk("b out_data", 32'(b_out_data), 32'(b_word[b_seq[i]]));
    end
    b_in_valid = 3'b001;
    step();
    chk("b wrap sel", 32'(b_out_sel), 32'd0);
    chk("b wrap data", 32'(b_out_data), 32'hBEEF);
    b_in_valid = 3'b000;
    step();
    chk("b drain valid", 32'(b_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, arbitrated N-to-1 data multiplexer; successor to the combinational 8-bit muxes.
- Generalised in data width and channel count.
- Adds per-channel valid/ready handshakes, round-robin or fixed-priority selection, and a one-entry output register.
- Sits between multiple bus masters (fetch, load/store, IO) and a single shared consumer.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels; legal range 2..8.
- SEL_BITS, 2: grant index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  bit i: channel i presents data.
- in_ready  output  CHANNELS  bit i: channel i's word is accepted this cycle.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_BITS  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_sel hold an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async, asserted):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0 while reset is high.
  - Any word held at reset is dropped.
- Mid-operation reset:
  - Outputs clear immediately, without waiting for clk.
  - First grant after release follows rr_ptr=0.
- can_load = !out_valid | out_ready (output slot free, or being freed this cycle).
- Grant (combinational from in_valid, mode, rr_ptr):
  - mode=1: lowest-index valid channel.
  - mode=0: first valid channel searching rr_ptr, rr_ptr+1, ... with wrap modulo CHANNELS.
  - No valid channel: no grant.
- in_ready[i] = can_load & (granted channel == i). At most one in_ready bit high; all zero when no grant.
- Transfer on clk edge when granted and can_load:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Output side:
  - out_valid & out_ready with no new grant: out_valid <= 0; out_data/out_sel keep their last values.
  - out_valid & !out_ready: out_data, out_sel, out_valid held stable (no change, no overwrite); in_ready all 0.
- Latency and throughput:
  - One cycle from accepted input to out_valid.
  - One word per cycle sustained when out_ready stays high; output and input handshakes in the same cycle are legal.
- rr_ptr update:
  - mode=0 transfer: rr_ptr <= (g+1) mod CHANNELS; wraps from CHANNELS-1 to 0.
  - mode=1 transfer: rr_ptr unchanged.
  - No transfer: rr_ptr unchanged.
- mode is sampled each cycle; switching it takes effect on the next grant decision and never disturbs a held output.
- in_valid dropped before acceptance is legal; that channel simply loses eligibility.
- Out-of-range channel indices are never granted, including when CHANNELS is not a power of two.

Test Plan:
- Reset: assert reset mid-transfer with out_valid=1, out_data=8'hA5 -> out_valid=0, out_data=0, out_sel=0 before the next clk edge; in_ready=0.
- Round-robin fairness: mode=0, in_valid=4'b1111, out_ready=1 held, data ch0..3 = 8'h10, 8'h21, 8'h32, 8'h43 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, matching data.
- Fixed priority: mode=1, in_valid=4'b1010 constant, out_ready=1 -> out_sel=1 every cycle; ch3 never granted; rr_ptr unchanged.
- Backpressure: out_valid=1 with 8'h5C from ch2, out_ready=0 for 3 cycles, in_valid=4'b1111 -> out_data=8'h5C and out_sel=2 stable, in_ready=0; out_ready=1 -> next word comes from ch3 (rr_ptr=3).
- Wrap and sparse grant: mode=0, rr_ptr=3, in_valid=4'b0011 -> ch0 granted, rr_ptr becomes 1; next grant is ch1.
- Parameter sweep: WIDTH=16, CHANNELS=3, SEL_BITS=2, all valid -> out_sel cycles 0,1,2,0; index 3 never appears; 16-bit data passes intact (e.g. 16'hBEEF).
